fir_cascade: RTL and testbench

- Latency-insensitive FIR pipeline: N_STAGES credit-wrapped FIR stages in series between a credit-based upstream port and a credit-based downstream port.
- Each token carries a data-valid bit plus a signed sample. Only tokens whose data-valid bit is set advance the filter history.
- With the default coefficients every stage is identity, so the output sample stream equals the input sample stream.

---
 rtl/fir_cascade_pkg.sv | 18 +
 rtl/fir_credit_stage.sv | 98 +++++++++
 rtl/fir_cascade.sv | 59 +++++
 tb/tb_fir_cascade.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_cascade_pkg.sv
// rtl/fir_cascade_pkg.sv - shared widths, types and constants for the credit-based FIR cascade
// Optional feature macro FIR_CASCADE_SAT_EN is consumed by fir_credit_stage.
package fir_cascade_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_ADDR  = 6;
    localparam int N_CREDITS  = 2 ** FIFO_ADDR;
    localparam int COEFF_FRAC = 14;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [15:0]           coeff_t;

    typedef struct packed {
        logic    data_valid;
        sample_t data;
    } token_t;

endpackage

// File: rtl/fir_credit_stage.sv
// rtl/fir_credit_stage.sv - one credit-wrapped FIR stage: input FIFO, downstream credit counter, 2-tap MAC, output register
// FIR_CASCADE_SAT_EN defined: saturate the result; otherwise keep the low DATA_WIDTH bits (wrap).
module fir_credit_stage #(
    parameter int                      DATA_WIDTH = fir_cascade_pkg::DATA_WIDTH,
    parameter int                      FIFO_ADDR  = fir_cascade_pkg::FIFO_ADDR,
    parameter fir_cascade_pkg::coeff_t C0         = 16'sd16384,
    parameter fir_cascade_pkg::coeff_t C1         = 16'sd0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic                         in_data_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         credit_return,
    output logic                         out_valid,
    output logic                         out_data_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         credit_in
);
    import fir_cascade_pkg::*;

    localparam int                 DEPTH      = 2 ** FIFO_ADDR;
    localparam int                 ACC_W      = DATA_WIDTH + 17;
    localparam logic [FIFO_ADDR:0] CREDIT_MAX = (FIFO_ADDR + 1)'(DEPTH);
    localparam logic [FIFO_ADDR:0] PTR_ONE    = (FIFO_ADDR + 1)'(1);

    logic [DATA_WIDTH:0]          mem [DEPTH];
    logic [FIFO_ADDR:0]           wr_ptr, rd_ptr, credits;
    logic                         empty, full, push, pop, head_valid;
    logic [DATA_WIDTH:0]          head;
    logic signed [DATA_WIDTH-1:0] x, x_prev, y;
    logic signed [ACC_W-1:0]      acc;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[FIFO_ADDR] != rd_ptr[FIFO_ADDR]) &&
                        (wr_ptr[FIFO_ADDR-1:0] == rd_ptr[FIFO_ADDR-1:0]);
    assign push       = in_valid && !full;
    assign pop        = !empty && (credits != '0);
    assign head       = mem[rd_ptr[FIFO_ADDR-1:0]];
    assign head_valid = head[DATA_WIDTH];
    assign x          = head[DATA_WIDTH-1:0];

    // Operands are sign-extended to the accumulator width, so modular products give the signed result.
    assign acc = {{(ACC_W-16){C0[15]}}, C0} * {{(ACC_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x}
               + {{(ACC_W-16){C1[15]}}, C1} * {{(ACC_W-DATA_WIDTH){x_prev[DATA_WIDTH-1]}}, x_prev};

`ifdef FIR_CASCADE_SAT_EN
    logic unused_frac;
    assign unused_frac = ^acc[COEFF_FRAC-1:0];

    always_comb begin
        y = acc[COEFF_FRAC +: DATA_WIDTH];
        if (acc[ACC_W-1:COEFF_FRAC+DATA_WIDTH-1] != {(ACC_W-COEFF_FRAC-DATA_WIDTH+1){acc[ACC_W-1]}})
            y = acc[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    logic unused_bits;
    assign unused_bits = ^{acc[ACC_W-1:COEFF_FRAC+DATA_WIDTH], acc[COEFF_FRAC-1:0]};
    assign y = acc[COEFF_FRAC +: DATA_WIDTH];
`endif

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr[FIFO_ADDR-1:0]] <= {in_data_valid, in_data};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            credits        <= CREDIT_MAX;
            x_prev         <= '0;
            credit_return  <= 1'b0;
            out_valid      <= 1'b0;
            out_data_valid <= 1'b0;
            out_data       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            credit_return  <= pop;
            out_valid      <= pop;
            out_data_valid <= pop && head_valid;
            out_data       <= (pop && head_valid) ? y : '0;
            if (pop && head_valid)
                x_prev <= x;
            // Returns beyond a full credit pool are dropped.
            if (credit_in && !pop && credits != CREDIT_MAX)
                credits <= credits + PTR_ONE;
            else if (pop && !credit_in)
                credits <= credits - PTR_ONE;
        end
    end

    assert property (@(posedge clock) disable iff (!reset) !(in_valid && full));

endmodule

// File: rtl/fir_cascade.sv
// rtl/fir_cascade.sv - N_STAGES credit-wrapped FIR stages in series between credit-based upstream and downstream ports
// FIR_CASCADE_SAT_EN selects saturating (defined) or wrapping (undefined) stage arithmetic.
module fir_cascade #(
    parameter int                      DATA_WIDTH = fir_cascade_pkg::DATA_WIDTH,
    parameter int                      N_STAGES   = 4,
    parameter int                      FIFO_ADDR  = fir_cascade_pkg::FIFO_ADDR,
    parameter fir_cascade_pkg::coeff_t C0         = 16'sd16384,
    parameter fir_cascade_pkg::coeff_t C1         = 16'sd0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_top_valid,
    input  logic                         i_top_data_valid,
    input  logic signed [DATA_WIDTH-1:0] i_top_data_data,
    output logic                         o_top_li_feedback,
    output logic                         o_top_valid,
    output logic                         o_top_data_valid,
    output logic signed [DATA_WIDTH-1:0] o_top_data_data,
    input  logic                         i_top_li_feedback
);
    import fir_cascade_pkg::*;

    // Index k is the input side of stage k; index N_STAGES is the downstream port.
    logic [N_STAGES:0]                 tok_valid, tok_data_valid, credit_strobe;
    logic [N_STAGES:0][DATA_WIDTH-1:0] tok_data;

    assign tok_valid[0]            = i_top_valid;
    assign tok_data_valid[0]       = i_top_data_valid;
    assign tok_data[0]             = i_top_data_data;
    assign credit_strobe[N_STAGES] = i_top_li_feedback;

    generate
        for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
            fir_credit_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_ADDR  (FIFO_ADDR),
                .C0         (C0),
                .C1         (C1)
            ) u_stage (
                .clock          (clock),
                .reset          (reset),
                .in_valid       (tok_valid[k]),
                .in_data_valid  (tok_data_valid[k]),
                .in_data        (tok_data[k]),
                .credit_return  (credit_strobe[k]),
                .out_valid      (tok_valid[k+1]),
                .out_data_valid (tok_data_valid[k+1]),
                .out_data       (tok_data[k+1]),
                .credit_in      (credit_strobe[k+1])
            );
        end
    endgenerate

    assign o_top_li_feedback = credit_strobe[0];
    assign o_top_valid       = tok_valid[N_STAGES];
    assign o_top_data_valid  = tok_data_valid[N_STAGES];
    assign o_top_data_data   = tok_data[N_STAGES];

endmodule

// File: tb/tb_fir_cascade.sv
// tb/tb_fir_cascade.sv - directed self-checking bench for fir_cascade
module tb_fir_cascade;
    import fir_cascade_pkg::*;

`ifdef FIR_CASCADE_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = -5536;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic               id_v = 1'b0, id_dv = 1'b0, id_fb = 1'b0;
    logic signed [15:0] id_d = '0;
    logic               id_credit, id_ov, id_odv;
    logic signed [15:0] id_od;

    logic               cf_v = 1'b0;
    logic signed [15:0] ha_d = '0, sa_d = '0;
    logic               ha_credit, ha_ov, ha_odv, sa_credit, sa_ov, sa_odv;
    logic signed [15:0] ha_od, sa_od;

    fir_cascade u_id (
        .clock(clock), .reset(reset),
        .i_top_valid(id_v), .i_top_data_valid(id_dv), .i_top_data_data(id_d),
        .o_top_li_feedback(id_credit),
        .o_top_valid(id_ov), .o_top_data_valid(id_odv), .o_top_data_data(id_od),
        .i_top_li_feedback(id_fb)
    );

    fir_cascade #(.N_STAGES(1), .C0(16'sd8192), .C1(16'sd8192)) u_half (
        .clock(clock), .reset(reset),
        .i_top_valid(cf_v), .i_top_data_valid(1'b1), .i_top_data_data(ha_d),
        .o_top_li_feedback(ha_credit),
        .o_top_valid(ha_ov), .o_top_data_valid(ha_odv), .o_top_data_data(ha_od),
        .i_top_li_feedback(1'b1)
    );

    fir_cascade #(.N_STAGES(1), .C0(16'sd16384), .C1(16'sd16384)) u_sat (
        .clock(clock), .reset(reset),
        .i_top_valid(cf_v), .i_top_data_valid(1'b1), .i_top_data_data(sa_d),
        .o_top_li_feedback(sa_credit),
        .o_top_valid(sa_ov), .o_top_data_valid(sa_odv), .o_top_data_data(sa_od),
        .i_top_li_feedback(1'b1)
    );

    token_t             id_q[$];
    logic signed [15:0] ha_q[$], sa_q[$];
    int cyc = 0, first_in = -1, first_out = -1, sent = 0, returned = 0;

    always @(negedge clock) begin
        cyc++;
        if (reset) begin
            if (id_credit) returned++;
            if (id_v && first_in < 0) first_in = cyc;
            if (id_ov) begin
                if (first_out < 0) first_out = cyc;
                id_q.push_back({id_odv, id_od});
            end
            if (ha_ov && ha_odv) ha_q.push_back(ha_od);
            if (sa_ov && sa_odv) sa_q.push_back(sa_od);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic put(input logic dv, input logic signed [15:0] d);
        int guard = 0;
        while (sent - returned >= N_CREDITS && guard < 500) begin
            tick(1);
            guard++;
        end
        if (guard >= 500) begin
            n_vec++;
            n_err++;
            $error("FAIL credit_wait: observed %0d waited cycles, expected < 500", guard);
        end
        id_v = 1'b1; id_dv = dv; id_d = d;
        sent++;
        tick(1);
        id_v = 1'b0; id_dv = 1'b0; id_d = '0;
    endtask

    task automatic wait_q(input int n, input int budget);
        int k = 0;
        while (id_q.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic check_stream(input string tag, input int base, input int n);
        token_t t;
        check({tag, "_count"}, id_q.size(), n);
        for (int i = 0; i < n && id_q.size() > 0; i++) begin
            t = id_q.pop_front();
            check({tag, "_data"}, t.data, base + i);
            check({tag, "_dv"}, t.data_valid, 1);
        end
    endtask

    initial begin
        #500000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        int n_inv, vi;
        longint sq;
        token_t t;
        int ha_exp[3];
        int sa_exp[3];
        ha_exp = '{50, 150, 250};
        sa_exp = '{30000, SAT_EXP, 30000};

        #1;
        check("rst_valid", id_ov, 0);
        check("rst_dv", id_odv, 0);
        check("rst_data", id_od, 0);
        check("rst_feedback", id_credit, 0);
        tick(2);
        reset = 1'b1;
        id_fb = 1'b1;

        // Identity stream with full downstream credit.
        for (int i = 0; i < 200; i++) put(1'b1, 16'(i));
        wait_q(200, 400);
        tick(5);
        check("t1_latency", first_out - first_in, 8);
        check_stream("t1", 0, 200);

        // Bubbles and data-invalid tokens mixed into the stream.
        n_inv = 0;
        for (int i = 0; i < 200; i++) begin
            put(1'b1, 16'(i));
            if (i % 3 == 0) begin
                put(1'b0, 16'sh7abc);
                n_inv++;
            end
            if (i % 5 == 0) tick(1);
        end
        wait_q(267, 800);
        tick(5);
        check("t2_count", id_q.size(), 267);
        vi = 0;
        sq = 0;
        while (id_q.size() > 0) begin
            t = id_q.pop_front();
            if (t.data_valid) begin
                check("t2_data", t.data, vi);
                sq += longint'(t.data - vi) * longint'(t.data - vi);
                vi++;
            end else begin
                check("t2_inv_data", t.data, 0);
            end
        end
        check("t2_valid_count", vi, 200);
        check("t2_sq_err", 32'(sq), 0);

        // Downstream withholds credit: exactly N_CREDITS tokens leave, then the rest drain on release.
        id_fb = 1'b0;
        for (int i = 0; i < 200; i++) put(1'b1, 16'(1000 + i));
        tick(40);
        check("t3_stalled_count", id_q.size(), 64);
        tick(20);
        check("t3_hold_count", id_q.size(), 64);
        check("t3_hold_valid", id_ov, 0);
        id_fb = 1'b1;
        wait_q(200, 1000);
        tick(5);
        check_stream("t3", 1000, 200);

        // Two-tap arithmetic on single-stage cascades.
        cf_v = 1'b1; ha_d = 16'sd100; sa_d = 16'sd30000;
        tick(1);
        ha_d = 16'sd200; sa_d = 16'sd30000;
        tick(1);
        ha_d = 16'sd300; sa_d = 16'sd0;
        tick(1);
        cf_v = 1'b0; ha_d = '0; sa_d = '0;
        tick(8);
        check("t4_half_count", ha_q.size(), 3);
        for (int i = 0; i < 3 && i < ha_q.size(); i++) check("t4_half_data", ha_q[i], ha_exp[i]);
        check("t4_sat_count", sa_q.size(), 3);
        for (int i = 0; i < 3 && i < sa_q.size(); i++) check("t4_sat_data", sa_q[i], sa_exp[i]);

        // Reset in the middle of a stream.
        id_q.delete();
        for (int i = 0; i < 12; i++) put(1'b1, 16'(500 + i));
        check("t5_pre_valid", id_ov, 1);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_valid", id_ov, 0);
        check("t5_rst_dv", id_odv, 0);
        check("t5_rst_data", id_od, 0);
        check("t5_rst_feedback", id_credit, 0);
        check("t5_rst_half_valid", ha_ov, 0);
        check("t5_rst_sat_valid", sa_ov, 0);
        check("t5_rst_cf_feedback", 32'(ha_credit | sa_credit), 0);
        tick(2);
        id_q.delete();
        sent = 0;
        returned = 0;
        reset = 1'b1;
        tick(20);
        check("t5_no_tokens", id_q.size(), 0);
        for (int i = 0; i < 10; i++) put(1'b1, 16'(i));
        wait_q(10, 100);
        tick(3);
        check_stream("t5", 0, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
